ro_puf_engine: RTL and testbench

Parametrised ring-oscillator PUF engine, the next generation of the serialised 8-bit RO PUF top. It holds no oscillators: it takes two external oscillator banks, picks one oscillator per bank for each response bit using a challenge-seeded LFSR, and compares them by frequency. The comparison runs in one of two modes, a fixed counting window or a race to a threshold. It assembles a RESP_W-bit response behind a start/valid handshake and drives the bank enable.

---
 rtl/ro_puf_pkg.sv | 36 +++
 rtl/ro_puf_engine_if.sv | 24 ++
 rtl/ro_edge_counter.sv | 46 ++++
 rtl/ro_puf_engine.sv | 161 ++++++++++++++++
 tb/tb_ro_puf_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types, constants and LFSR step for the RO PUF engine
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SELECT,
    ST_SETTLE,
    ST_COUNT,
    ST_DECIDE,
    ST_DONE
  } state_e;

  localparam int SETTLE_CYC = 4;

  // Tap masks: bit i set means lfsr[i] feeds the XOR that becomes the new LSB.
  localparam logic [31:0] TAPS8  = 32'h0000_00B8;  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [31:0] TAPS16 = 32'h0000_D008;  // x^16 + x^15 + x^13 + x^4 + 1
  localparam logic [31:0] TAPS32 = 32'h8020_0003;  // x^32 + x^22 + x^2 + x + 1

  // One Fibonacci step, shifting left; the result is masked to 'width' bits.
  function automatic logic [31:0] next_lfsr(input logic [31:0] s, input int width);
    logic [31:0] taps;
    logic [31:0] mask;
    logic        fb;
    case (width)
      16:      taps = TAPS16;
      32:      taps = TAPS32;
      default: taps = TAPS8;
    endcase
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    fb   = ^(s & taps);
    return ((s << 1) | {31'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/ro_puf_engine_if.sv
// rtl/ro_puf_engine_if.sv - start/response handshake bundle of the RO PUF engine
// master drives start/mode/chall_in; slave (the engine) drives busy/resp_valid/response/timeout.
interface ro_puf_engine_if #(
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8
);
  logic              start;
  logic              mode;
  logic [CHAL_W-1:0] chall_in;
  logic              busy;
  logic              resp_valid;
  logic [RESP_W-1:0] response;
  logic              timeout;

  modport master (
    output start, mode, chall_in,
    input  busy, resp_valid, response, timeout
  );

  modport slave (
    input  start, mode, chall_in,
    output busy, resp_valid, response, timeout
  );
endinterface

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - oscillator select, synchroniser, edge detect, saturating counter
// Ports: clk, rst; ro (bank outputs, async); sel (oscillator index);
//        clr (zero the counter); en (count enable); cnt (edge count).
module ro_edge_counter #(
  parameter int N_RO  = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_RO-1:0]  ro,
  input  logic [IDX_W-1:0] sel,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history.
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  always_comb begin
    sync_d = {sync_q[1:0], ro[sel]};
    rise   = sync_q[1] & ~sync_q[2];
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - ring-oscillator PUF engine top: FSM, LFSR, timer, response
// Ports: clk, rst (async, active-high); bus (slave side of ro_puf_engine_if);
//        ro_a/ro_b (oscillator banks, async); ro_en (bank enable).
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int N_RO   = 8,
  parameter int CHAL_W = 8,
  parameter int RESP_W = 8,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int THRESH = 256
) (
  input  logic            clk,
  input  logic            rst,
  ro_puf_engine_if.slave  bus,
  input  logic [N_RO-1:0] ro_a,
  input  logic [N_RO-1:0] ro_b,
  output logic            ro_en
);

  localparam int IDX_W    = $clog2(N_RO);
  localparam int BIT_W    = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int TIMER_W  = $clog2(WINDOW);
  localparam int SETTLE_W = $clog2(SETTLE_CYC);

  state_e              state_q, state_d;
  logic [CHAL_W-1:0]   chall_q, chall_d;
  logic                mode_q, mode_d;
  logic [CHAL_W-1:0]   lfsr_q, lfsr_d;
  logic [CHAL_W-1:0]   lfsr_step;
  logic [IDX_W-1:0]    sel_a_q, sel_a_d;
  logic [IDX_W-1:0]    sel_b_q, sel_b_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [RESP_W-1:0]   response_q, response_d;
  logic                timeout_q, timeout_d;
  logic                ro_en_q, ro_en_d;

  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic                cnt_clr, cnt_en;
  logic                a_hit, b_hit, race_done, bit_val;

  ro_edge_counter #(.N_RO(N_RO), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .ro(ro_a), .sel(sel_a_q),
    .clr(cnt_clr), .en(cnt_en), .cnt(cnt_a)
  );

  ro_edge_counter #(.N_RO(N_RO), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .ro(ro_b), .sel(sel_b_q),
    .clr(cnt_clr), .en(cnt_en), .cnt(cnt_b)
  );

  always_comb begin
    a_hit     = (cnt_a >= CNT_W'(THRESH));
    b_hit     = (cnt_b >= CNT_W'(THRESH));
    race_done = mode_q && (a_hit || b_hit);
    // Freeze both counters in the race exit cycle so DECIDE sees who crossed first.
    cnt_en    = (state_q == ST_COUNT) && !race_done;
    cnt_clr   = (state_q == ST_SELECT) || (state_q == ST_SETTLE);
    bit_val   = mode_q ? (a_hit && !b_hit) : (cnt_a > cnt_b);
    lfsr_step = CHAL_W'(next_lfsr(32'(lfsr_q), CHAL_W));
  end

  always_comb begin
    state_d    = state_q;
    chall_d    = chall_q;
    mode_d     = mode_q;
    lfsr_d     = lfsr_q;
    sel_a_d    = sel_a_q;
    sel_b_d    = sel_b_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
    settle_d   = settle_q;
    response_d = response_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          chall_d    = bus.chall_in;
          mode_d     = bus.mode;
          response_d = '0;
          timeout_d  = 1'b0;
          state_d    = ST_SEED;
        end
      end
      ST_SEED: begin
        // An all-zero seed would lock the LFSR.
        lfsr_d    = (chall_q == '0) ? CHAL_W'(1) : chall_q;
        bit_idx_d = '0;
        state_d   = ST_SELECT;
      end
      ST_SELECT: begin
        lfsr_d   = lfsr_step;
        sel_a_d  = lfsr_step[IDX_W-1:0];
        sel_b_d  = lfsr_step[CHAL_W-1 -: IDX_W];
        timer_d  = '0;
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        settle_d = settle_q + SETTLE_W'(1);
        if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        timer_d = timer_q + TIMER_W'(1);
        if ((timer_q == TIMER_W'(WINDOW - 1)) || race_done) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        response_d[bit_idx_q] = bit_val;
        if (mode_q && !a_hit && !b_hit) timeout_d = 1'b1;
        if (bit_idx_q == BIT_W'(RESP_W - 1)) begin
          state_d = ST_DONE;
        end else begin
          bit_idx_d = bit_idx_q + BIT_W'(1);
          state_d   = ST_SELECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ro_en_d = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chall_q    <= '0;
      mode_q     <= 1'b0;
      lfsr_q     <= '0;
      sel_a_q    <= '0;
      sel_b_q    <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
      settle_q   <= '0;
      response_q <= '0;
      timeout_q  <= 1'b0;
      ro_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chall_q    <= chall_d;
      mode_q     <= mode_d;
      lfsr_q     <= lfsr_d;
      sel_a_q    <= sel_a_d;
      sel_b_q    <= sel_b_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      settle_q   <= settle_d;
      response_q <= response_d;
      timeout_q  <= timeout_d;
      ro_en_q    <= ro_en_d;
    end
  end

  assign ro_en          = ro_en_q;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.response   = response_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - scoreboard bench for ro_puf_engine
module tb_ro_puf_engine;

  localparam int N_RO   = 8;
  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;
  localparam int CNT_W  = 16;
  localparam int WINDOW = 64;
  localparam int THRESH = 8;
  localparam int LAT    = 2 + RESP_W * (6 + WINDOW);

  typedef struct {
    logic [7:0] resp;
    logic       to;
    int         done_cyc;
  } resp_exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_RO-1:0] ro_a, ro_b;
  logic            ro_en;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;

  resp_exp_t  resp_q[$];
  logic [5:0] sel_q[$];
  int         cnt_q[$];  // 0: COUNT phase exactly WINDOW, 1: strictly shorter

  int ha_cfg = 0, hb_cfg = 0;
  bit osc_reload = 1'b0;

  ro_puf_engine_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

  ro_puf_engine #(
    .N_RO(N_RO), .CHAL_W(CHAL_W), .RESP_W(RESP_W),
    .CNT_W(CNT_W), .WINDOW(WINDOW), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .ro_a(ro_a), .ro_b(ro_b), .ro_en(ro_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Oscillator banks: every oscillator in a bank shares one waveform; half period 0 holds low.
  initial begin
    int ca, cb, ha, hb;
    ca = 0; cb = 0; ha = 0; hb = 0;
    ro_a = '0; ro_b = '0;
    forever begin
      @(negedge clk);
      if (osc_reload) begin
        ha = ha_cfg; hb = hb_cfg; ca = 0; cb = 0;
        ro_a = '0; ro_b = '0;
        osc_reload = 1'b0;
      end else begin
        if (ha != 0) begin ca++; if (ca >= ha) begin ca = 0; ro_a = ~ro_a; end end
        if (hb != 0) begin cb++; if (cb >= hb) begin cb = 0; ro_b = ~ro_b; end end
      end
    end
  end

  // Monitor: pops expectations as the DUT presents selections, COUNT phases and responses.
  initial begin
    int        en_len;
    bit        prev_en, prev_rv;
    resp_exp_t r;
    logic [5:0] es;
    int         k;
    en_len = 0; prev_en = 0; prev_rv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_len = 0; prev_en = 0; prev_rv = 0;
      end else begin
        if (ro_en && !prev_en) begin
          if (sel_q.size() == 0) chk("unexpected_select", 1, 0);
          else begin
            es = sel_q.pop_front();
            chk("sel_pair", {dut.sel_a_q, dut.sel_b_q}, es);
          end
        end
        if (ro_en) en_len++;
        if (!ro_en && prev_en) begin
          if (cnt_q.size() == 0) chk("unexpected_count_phase", 1, 0);
          else begin
            k = cnt_q.pop_front();
            if (k == 0) chk("count_len_exact", en_len - 4, WINDOW);
            else        chk("count_len_short", (en_len - 4) < WINDOW, 1);
          end
          en_len = 0;
        end
        if (bus.resp_valid && !prev_rv) begin
          if (resp_q.size() == 0) chk("unexpected_resp_valid", 1, 0);
          else begin
            r = resp_q.pop_front();
            chk("response", bus.response, r.resp);
            chk("timeout", bus.timeout, r.to);
            if (r.done_cyc >= 0) chk("latency", cyc, r.done_cyc);
          end
        end
        prev_en = ro_en;
        prev_rv = bus.resp_valid;
      end
    end
  end

  task automatic set_osc(input int a, input int b);
    ha_cfg = a; hb_cfg = b; osc_reload = 1'b1;
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] ch, input logic md, input logic [7:0] er,
                        input logic et, input int ckind, input bit exact_lat);
    logic [7:0] s;
    resp_exp_t  r;
    s = (ch == 8'h00) ? 8'h01 : ch;
    for (int i = 0; i < RESP_W; i++) begin
      s = ref_step(s);
      sel_q.push_back({s[2:0], s[7:5]});
      cnt_q.push_back(ckind);
    end
    @(negedge clk);
    bus.chall_in = ch; bus.mode = md; bus.start = 1'b1;
    r.resp = er; r.to = et; r.done_cyc = exact_lat ? cyc + LAT : -1;
    resp_q.push_back(r);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.resp_valid && n < 3 * LAT) begin @(negedge clk); n++; end
    chk("done_in_time", bus.resp_valid, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, rises;
    bit prev;
    rst = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.chall_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_response", bus.response, 0);
    chk("rst_timeout", bus.timeout, 0);

    // Window mode, A faster than B
    set_osc(2, 3);
    launch(8'hA5, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    wait_done();

    // Window mode tie
    set_osc(3, 3);
    launch(8'h3C, 1'b0, 8'h00, 1'b0, 0, 1'b1);
    wait_done();

    // Race, B faster
    set_osc(3, 2);
    launch(8'h5A, 1'b1, 8'h00, 1'b0, 1, 1'b0);
    wait_done();

    // Race, A faster
    set_osc(2, 4);
    launch(8'hC3, 1'b1, 8'hFF, 1'b0, 1, 1'b0);
    wait_done();

    // Race, both cross in the same cycle
    set_osc(2, 2);
    launch(8'h81, 1'b1, 8'h00, 1'b0, 1, 1'b0);
    wait_done();

    // Race, no oscillation: every bit times out at WINDOW
    set_osc(0, 0);
    launch(8'h42, 1'b1, 8'h00, 1'b1, 0, 1'b1);
    wait_done();

    // Zero challenge plus a start pulse while busy that must be ignored
    set_osc(2, 3);
    launch(8'h00, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    repeat (100) @(negedge clk);
    bus.chall_in = 8'hFF; bus.mode = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Reset in the middle of the third bit's COUNT phase
    launch(8'h77, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    n = 0; rises = 0; prev = 1'b0;
    while (rises < 3 && n < 2000) begin
      @(negedge clk); n++;
      if (ro_en && !prev) rises++;
      prev = ro_en;
    end
    chk("third_select_seen", rises, 3);
    repeat (10) @(negedge clk);
    chk("pre_rst_partial", bus.response, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ro_en", ro_en, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_response", bus.response, 0);
    chk("midrst_resp_valid", bus.resp_valid, 0);
    sel_q.delete(); cnt_q.delete(); resp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(8'h77, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    wait_done();

    chk("resp_queue_drained", resp_q.size(), 0);
    chk("sel_queue_drained", sel_q.size(), 0);
    chk("cnt_queue_drained", cnt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
